// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin memory arbiter with in-order read-response routing
// Define ARB_WRR_EN for weighted round robin driven by the per-channel weight input.
package system_widths_pkg;
  localparam int ADDR_W = 16;
endpackage

module mem_arbiter_rr #(
  parameter int N        = 3,
  parameter int ADDR_W   = system_widths_pkg::ADDR_W,
  parameter int DATA_W   = 8,
  parameter int MAX_OUT  = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N-1:0]                   req_valid,
  output logic [N-1:0]                   req_ready,
  input  logic [N-1:0]                   req_we,
  input  logic [N-1:0][ADDR_W-1:0]       req_addr,
  input  logic [N-1:0][DATA_W-1:0]       req_wdata,
  output logic [N-1:0]                   resp_valid,
  output logic [DATA_W-1:0]              resp_data,
  input  logic [N-1:0][WEIGHT_W-1:0]     weight,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_we,
  output logic [ADDR_W-1:0]              mem_req_addr,
  output logic [DATA_W-1:0]              mem_req_wdata,
  input  logic                           mem_resp_valid,
  input  logic [DATA_W-1:0]              mem_resp_data,
  output logic [$clog2(N)-1:0]           grant_id_dbg,
  output logic [$clog2(MAX_OUT):0]       outstanding_dbg,
  output logic                           err_orphan_resp
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [IW-1:0] last_grant, lock_id, grant;
  logic          locked, grant_valid;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] id_fifo [MAX_OUT];
  logic [N-1:0]  eligible;
  logic          xfer, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads need a free response slot; the count used is the pre-pop value.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++)
      eligible[i] = req_valid[i] && (req_we[i] || (cnt < MAX_CNT));
  end

`ifdef ARB_WRR_EN
  logic [WEIGHT_W-1:0] credits;
  logic [WEIGHT_W-1:0] load_w;
  assign load_w = (weight[grant] == '0) ? '0 : weight[grant] - WEIGHT_W'(1);

  // Credits belong to last_grant; a fresh grant loads its weight minus this transfer.
  always_ff @(posedge clk) begin
    if (reset)
      credits <= '0;
    else if (xfer)
      credits <= (grant == last_grant && credits != '0) ? credits - WEIGHT_W'(1) : load_w;
  end
`else
  logic unused_weight;
  assign unused_weight = ^weight;
`endif

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (locked && req_valid[lock_id]) begin
      grant       = lock_id;
      grant_valid = 1'b1;
    end
`ifdef ARB_WRR_EN
    else if (credits != '0 && eligible[last_grant]) begin
      grant       = last_grant;
      grant_valid = 1'b1;
    end
`endif
    else begin
      // Walk backwards so the nearest eligible channel after last_grant wins.
      for (int k = N; k >= 1; k--) begin
        if (eligible[(int'(last_grant) + k) % N]) begin
          grant       = IW'((int'(last_grant) + k) % N);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign xfer = grant_valid && mem_req_ready;
  assign push = xfer && !req_we[grant];
  assign pop  = mem_resp_valid && (cnt != '0);

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant] = 1'b1;
  end

  assign mem_req_valid   = grant_valid;
  assign mem_req_we      = req_we[grant];
  assign mem_req_addr    = req_addr[grant];
  assign mem_req_wdata   = req_wdata[grant];
  assign grant_id_dbg    = grant;
  assign outstanding_dbg = cnt;

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant      <= IW'(N - 1);
      locked          <= 1'b0;
      lock_id         <= '0;
      cnt             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      err_orphan_resp <= 1'b0;
    end else begin
      locked  <= grant_valid && !mem_req_ready;
      lock_id <= grant;
      if (xfer) last_grant <= grant;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt        <= cnt + CW'(push) - CW'(pop);
      resp_valid <= '0;
      if (pop) begin
        resp_valid[id_fifo[rd_ptr]] <= 1'b1;
        resp_data                   <= mem_resp_data;
      end
      if (mem_resp_valid && cnt == '0) err_orphan_resp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - randomized and directed checks of mem_arbiter_rr against a queue-based model
module tb_mem_arbiter_rr;
  localparam int N        = 3;
  localparam int ADDR_W   = system_widths_pkg::ADDR_W;
  localparam int DATA_W   = 8;
  localparam int MAX_OUT  = 4;
  localparam int WEIGHT_W = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [N-1:0]               req_valid, req_ready, req_we, resp_valid;
  logic [N-1:0][ADDR_W-1:0]   req_addr;
  logic [N-1:0][DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]          resp_data;
  logic [N-1:0][WEIGHT_W-1:0] weight;
  logic                       mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0]          mem_req_addr;
  logic [DATA_W-1:0]          mem_req_wdata;
  logic                       mem_resp_valid;
  logic [DATA_W-1:0]          mem_resp_data;
  logic [$clog2(N)-1:0]       grant_id_dbg;
  logic [$clog2(MAX_OUT):0]   outstanding_dbg;
  logic                       err_orphan_resp;

  mem_arbiter_rr #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .WEIGHT_W(WEIGHT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .weight(weight), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .grant_id_dbg(grant_id_dbg),
    .outstanding_dbg(outstanding_dbg), .err_orphan_resp(err_orphan_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef ARB_WRR_EN
  localparam bit WRR = 1'b1;
`else
  localparam bit WRR = 1'b0;
`endif

  // Model: who was served last, who is locked, a queue of channels awaiting read data.
  int               m_last, m_lock_id, m_credits, m_xfer;
  bit               m_lock, m_err;
  int               m_q[$];
  logic [N-1:0]     m_rv;
  logic [DATA_W-1:0] m_rd;

  logic                     s_mrv, s_mwe, s_err;
  logic [$clog2(N)-1:0]     s_gid;
  logic [ADDR_W-1:0]        s_addr;
  logic [N-1:0]             s_ready, s_rv;
  logic [DATA_W-1:0]        s_rd;
  logic [$clog2(MAX_OUT):0] s_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int c);
    return req_valid[c] && (req_we[c] || m_q.size() < MAX_OUT);
  endfunction

  function automatic int model_grant();
    if (m_lock && req_valid[m_lock_id]) return m_lock_id;
    if (WRR && m_credits > 0 && elig(m_last)) return m_last;
    for (int k = 1; k <= N; k++)
      if (elig((m_last + k) % N)) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_lock = 0; m_lock_id = 0; m_credits = 0; m_xfer = -1;
    m_q.delete(); m_rv = '0; m_rd = '0; m_err = 0;
  endtask

  // One cycle: compare at negedge, advance the model at the posedge, return just after it.
  task automatic step();
    int g;
    logic [N-1:0] er;
    int w;
    @(negedge clk);
    g = model_grant();
    s_mrv = mem_req_valid; s_gid = grant_id_dbg; s_addr = mem_req_addr; s_mwe = mem_req_we;
    s_ready = req_ready; s_out = outstanding_dbg; s_rv = resp_valid; s_rd = resp_data; s_err = err_orphan_resp;
    chk("mem_req_valid", s_mrv, 64'(g >= 0));
    if (g >= 0) begin
      chk("grant_id", s_gid, 64'(g));
      chk("mem_req_we", s_mwe, 64'(req_we[g]));
      chk("mem_req_addr", s_addr, 64'(req_addr[g]));
      chk("mem_req_wdata", mem_req_wdata, 64'(req_wdata[g]));
    end
    er = '0;
    if (g >= 0 && mem_req_ready) er[g] = 1'b1;
    chk("req_ready", s_ready, 64'(er));
    chk("outstanding", s_out, 64'(m_q.size()));
    chk("resp_valid", s_rv, 64'(m_rv));
    chk("resp_data", s_rd, 64'(m_rd));
    chk("err_orphan", s_err, 64'(m_err));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_rv = '0;
      if (mem_resp_valid) begin
        if (m_q.size() > 0) begin
          m_rv[m_q.pop_front()] = 1'b1;
          m_rd = mem_resp_data;
        end else m_err = 1;
      end
      m_xfer = (g >= 0 && mem_req_ready) ? g : -1;
      if (m_xfer >= 0) begin
        if (!req_we[g]) m_q.push_back(g);
        w = (weight[g] == 0) ? 1 : int'(weight[g]);
        if (g == m_last && m_credits > 0) m_credits--;
        else m_credits = w - 1;
        m_last = g;
      end
      m_lock = (g >= 0) && !mem_req_ready;
      m_lock_id = (g >= 0) ? g : 0;
    end
    #1;
  endtask

  task automatic clr_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int seq[12];

  initial begin
    clr_inputs();
    weight = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    step();
    chk("reset_mem_req_valid", s_mrv, 0);
    chk("reset_outstanding", s_out, 0);
    chk("reset_resp_valid", s_rv, 0);
    chk("reset_err", s_err, 0);
    reset = 1'b0;

    // Plain rotation with all channels reading.
    do_reset();
    for (int i = 0; i < N; i++) weight[i] = WEIGHT_W'(1);
    req_valid = '1; mem_req_ready = 1'b1;
    for (int i = 0; i < N; i++) req_addr[i] = ADDR_W'(16 * i);
    for (int j = 0; j < 6; j++) begin
      mem_resp_valid = (j > 0); mem_resp_data = DATA_W'(j);
      step();
      seq[j] = int'(s_gid);
    end
    for (int j = 0; j < 6; j++) chk($sformatf("rr_seq_%0d", j), 64'(seq[j]), 64'(j % 3));

    // Lock while mem_req_ready is low.
    do_reset();
    req_valid = 3'b010; req_addr[1] = 16'h1234; req_addr[0] = 16'h0abc;
    step();
    chk("lock_c1_grant", s_gid, 1);
    req_valid = 3'b011;
    step();
    chk("lock_c2_grant", s_gid, 1);
    chk("lock_c2_addr", s_addr, 16'h1234);
    step();
    chk("lock_c3_addr", s_addr, 16'h1234);
    mem_req_ready = 1'b1;
    step();
    chk("lock_c4_ready", s_ready, 3'b010);
    req_valid = 3'b001;
    step();
    chk("lock_after_grant", s_gid, 0);

    // Outstanding limit blocks reads but not writes.
    do_reset();
    req_valid = 3'b100; mem_req_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      req_addr[2] = ADDR_W'(j);
      step();
    end
    req_addr[2] = ADDR_W'(4);
    step();
    chk("full_blocked_valid", s_mrv, 0);
    chk("full_outstanding", s_out, 4);
    req_valid = 3'b101; req_we[0] = 1'b1; req_wdata[0] = 8'h5a;
    step();
    chk("full_write_ready", s_ready, 3'b001);
    chk("full_write_we", s_mwe, 1);

    // Responses route in request order.
    do_reset();
    mem_req_ready = 1'b1;
    req_valid = 3'b001; req_addr[0] = 16'h0010;
    step();
    req_valid = 3'b100; req_addr[2] = 16'h0020;
    step();
    req_valid = '0; mem_resp_valid = 1'b1; mem_resp_data = 8'hAA;
    step();
    mem_resp_data = 8'h55;
    step();
    chk("resp0_valid", s_rv, 3'b001);
    chk("resp0_data", s_rd, 8'hAA);
    mem_resp_valid = 1'b0;
    step();
    chk("resp2_valid", s_rv, 3'b100);
    chk("resp2_data", s_rd, 8'h55);

    // Orphan response is sticky until reset.
    do_reset();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    step();
    chk("orphan_set", s_err, 1);
    chk("orphan_no_resp", s_rv, 0);
    repeat (3) step();
    chk("orphan_sticky", s_err, 1);
    do_reset();
    step();
    chk("orphan_cleared", s_err, 0);

`ifdef ARB_WRR_EN
    do_reset();
    weight[0] = 4'd1; weight[1] = 4'd3; weight[2] = 4'd2;
    req_valid = '1; mem_req_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      mem_resp_valid = (j > 0);
      step();
      seq[j] = int'(s_gid);
    end
    begin
      int exp_w[6] = '{0, 1, 1, 1, 2, 2};
      for (int j = 0; j < 12; j++) chk($sformatf("wrr_seq_%0d", j), 64'(seq[j]), 64'(exp_w[j % 6]));
    end
`endif

    // Random traffic: requests hold until accepted.
    do_reset();
    for (int i = 0; i < N; i++) weight[i] = WEIGHT_W'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m_xfer == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_we[i]    = ($urandom % 3 == 0);
          req_addr[i]  = ADDR_W'($urandom);
          req_wdata[i] = DATA_W'($urandom);
        end
      end
      if (cyc % 500 == 250)
        for (int i = 0; i < N; i++) weight[i] = WEIGHT_W'($urandom_range(0, 3));
      mem_req_ready  = ($urandom % 4 != 0);
      mem_resp_valid = (m_q.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 300 == 0);
      mem_resp_data  = DATA_W'($urandom);
      reset          = ($urandom % 400 == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter N, default 3: number of requesting cache channels, range 2..16.
REQ-002 Parameter ADDR_W, default ADDR_W from system_widths_pkg: address width.
REQ-003 Parameter DATA_W, default 8: data width.
REQ-004 Parameter MAX_OUT, default 4: maximum outstanding reads, power of two, range 1..16.
REQ-005 Parameter WEIGHT_W, default 4: width of each per-channel weight.
REQ-006 Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [N]  per-channel request valid.
- req_ready  out  [N]  per-channel request accepted.
- req_we  in  [N]  1 = write, 0 = read.
- req_addr  in  [N][ADDR_W]  request address.
- req_wdata  in  [N][DATA_W]  write data.
- resp_valid  out  [N]  one-cycle read-response strobe.
- resp_data  out  [DATA_W]  read data, broadcast to all channels.
- weight  in  [N][WEIGHT_W]  per-channel burst weight; used only under ARB_WRR_EN.
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
- mem_req_we, mem_req_addr, mem_req_wdata  out  1/ADDR_W/DATA_W  selected request.
- mem_resp_valid, mem_resp_data  in  1/DATA_W  in-order read response; writes produce no response.
- grant_id_dbg  out  $clog2(N)  currently granted channel.
- outstanding_dbg  out  $clog2(MAX_OUT)+1  outstanding-read count.
- err_orphan_resp  out  1  sticky error flag.

Function
REQ-007 A channel is eligible when req_valid=1 and either req_we=1 or outstanding < MAX_OUT; count is taken before any same-cycle pop, with no bypass.
REQ-008 Round robin: search starts at last_grant+1 modulo N; the first eligible channel wins.
REQ-009 mem_req_valid=1 iff a grant exists; mem_req_* = granted channel's fields, combinational.
REQ-010 req_ready[g] = (grant==g) && mem_req_ready; a transfer occurs on mem_req_valid && mem_req_ready.
REQ-011 Lock: when mem_req_valid=1 and mem_req_ready=0, the grant is registered and held until the transfer, even if higher-priority requests appear.
REQ-012 On each transfer, last_grant takes the granted index, except as modified by REQ-020.
REQ-013 A read transfer pushes the channel index into the ID FIFO (depth MAX_OUT) and increments outstanding.
REQ-014 mem_resp_valid pops the FIFO head h.
- Next cycle: resp_valid[h]=1, resp_data = registered mem_resp_data.
- outstanding decrements.
- Latency: 1 cycle.
REQ-015 Simultaneous push and pop: outstanding is unchanged, and the FIFO pointers both advance and wrap modulo MAX_OUT.
REQ-016 mem_resp_valid with an empty FIFO: no resp_valid, no pointer change, and err_orphan_resp sets until reset.
REQ-017 At most one bit of resp_valid is high per cycle.
REQ-018 With no eligible channel, mem_req_valid=0 and last_grant holds.

Reset
REQ-019 On reset=1 at a clk edge:
- last_grant = N-1, so channel 0 has first priority.
- Lock cleared and FIFO pointers zeroed.
- outstanding_dbg=0, resp_valid=0, resp_data=0, err_orphan_resp=0.
- All credit counters = 0.
- Responses in flight during reset are discarded.

Configuration
REQ-020 Macro ARB_WRR_EN defined: weighted round robin.
- On grant, a credit counter loads weight[g]; weight 0 is treated as 1.
- Each transfer decrements the counter.
- While credits remain and channel g stays eligible, the grant stays on g and last_grant does not advance.
- At 0 credits, or when g is no longer eligible, the grant advances per REQ-008.
REQ-021 ARB_WRR_EN undefined: plain round robin per REQ-008/REQ-012, with the weight input ignored and no credit logic synthesised.

Verification
REQ-022 All three channels read continuously, mem_req_ready=1, macro off -> grants 0,1,2,0,1,2.
REQ-023 Channel 1 requests with mem_req_ready=0 for 3 cycles while channel 0 rises -> grant stays 1, mem_req_addr stable, channel 1 transfers on cycle 4.
REQ-024 MAX_OUT=4, five back-to-back reads from channel 2 with no responses -> fifth read blocked, outstanding_dbg=4; a write from channel 0 is still accepted.
REQ-025 Reads ch0@0x10, ch2@0x20; memory returns 0xAA then 0x55 -> resp_valid[0] with 0xAA, then resp_valid[2] with 0x55, one cycle after each mem_resp_valid.
REQ-026 mem_resp_valid pulse with outstanding=0 -> err_orphan_resp=1 and remains set until reset.
REQ-027 ARB_WRR_EN defined, weight={1,3,2} for ch0..ch2, all requesting -> grant sequence 0,1,1,1,2,2 repeating.
